// File: rtl/pipelined_addsub_nbits.sv
// Pipelined two's-complement adder/subtractor with the carry chain split into
// STAGES registered chunks, valid/ready on both sides and a full flag set.
module pipelined_addsub_nbits #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic                          stall;
  logic [WIDTH-1:0]              b_eff;
  logic [STAGES-1:0][WIDTH-1:0]  src_a;
  logic [STAGES-1:0][WIDTH-1:0]  src_b;
  logic [STAGES-1:0][WIDTH-1:0]  src_s;
  logic [STAGES-1:0]             src_c;
  logic [STAGES-1:0]             src_v;
  logic [STAGES-1:0][CW:0]       chunk_sum;
  logic [STAGES-1:0][WIDTH-1:0]  stage_s;
  logic [STAGES-1:0]             stage_c;

  assign b_eff    = op_sub ? ~b : b;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Stage k adds chunk k of its operands; lower chunks of the sum pass through.
  always_comb begin
    chunk_sum = '0;
    stage_s   = '0;
    stage_c   = '0;
    for (int k = 0; k < STAGES; k++) begin
      chunk_sum[k] = {1'b0, src_a[k][k*CW +: CW]} + {1'b0, src_b[k][k*CW +: CW]}
                   + {{CW{1'b0}}, src_c[k]};
      stage_s[k]   = src_s[k];
      stage_s[k][k*CW +: CW] = chunk_sum[k][CW-1:0];
      stage_c[k]   = chunk_sum[k][CW];
    end
  end

  if (STAGES > 1) begin : g_pipe
    logic [STAGES-2:0][WIDTH-1:0] pipe_a_q, pipe_a_d;
    logic [STAGES-2:0][WIDTH-1:0] pipe_b_q, pipe_b_d;
    logic [STAGES-2:0][WIDTH-1:0] pipe_s_q, pipe_s_d;
    logic [STAGES-2:0]            pipe_c_q, pipe_c_d;
    logic [STAGES-2:0]            pipe_v_q, pipe_v_d;

    always_comb begin
      pipe_a_d = src_a[STAGES-2:0];
      pipe_b_d = src_b[STAGES-2:0];
      pipe_s_d = stage_s[STAGES-2:0];
      pipe_c_d = stage_c[STAGES-2:0];
      pipe_v_d = src_v[STAGES-2:0];
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pipe_a_q <= '0;
        pipe_b_q <= '0;
        pipe_s_q <= '0;
        pipe_c_q <= '0;
        pipe_v_q <= '0;
      end else if (!stall) begin
        pipe_a_q <= pipe_a_d;
        pipe_b_q <= pipe_b_d;
        pipe_s_q <= pipe_s_d;
        pipe_c_q <= pipe_c_d;
        pipe_v_q <= pipe_v_d;
      end
    end

    assign src_a = {pipe_a_q, a};
    assign src_b = {pipe_b_q, b_eff};
    assign src_s = {pipe_s_q, {WIDTH{1'b0}}};
    assign src_c = {pipe_c_q, op_sub};
    assign src_v = {pipe_v_q, in_valid};
  end else begin : g_single
    assign src_a = a;
    assign src_b = b_eff;
    assign src_s = '0;
    assign src_c = op_sub;
    assign src_v = in_valid;
  end

  // Only the top chunk of the last stage's operands feeds an adder.
  logic unused_last_ops;
  assign unused_last_ops = ^{src_a[LAST], src_b[LAST]};

  logic [WIDTH-1:0] s_q, s_d;
  logic             out_valid_q, out_valid_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             negative_q, negative_d;
  logic             msb_cin;

  // Result registers only load on a valid op so they hold across bubbles.
  always_comb begin
    s_d         = s_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    negative_d  = negative_q;
    msb_cin     = 1'b0;
    out_valid_d = src_v[LAST];
    if (src_v[LAST]) begin
      s_d        = stage_s[LAST];
      carry_d    = stage_c[LAST];
      msb_cin    = stage_s[LAST][WIDTH-1] ^ src_a[LAST][WIDTH-1] ^ src_b[LAST][WIDTH-1];
      overflow_d = stage_c[LAST] ^ msb_cin;
      zero_d     = ~|stage_s[LAST];
      negative_d = stage_s[LAST][WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q         <= '0;
      out_valid_q <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
    end else if (!stall) begin
      s_q         <= s_d;
      out_valid_q <= out_valid_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      negative_q  <= negative_d;
    end
  end

  assign s         = s_q;
  assign out_valid = out_valid_q;
  assign carry_out = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign negative  = negative_q;

endmodule

// File: tb/tb_pipelined_addsub_nbits.sv
// Scoreboard bench: three configurations (32/4, 32/1, 16/2) driven with directed
// vectors, plus random ops with output back-pressure and a mid-flight reset.
module tb_pipelined_addsub_nbits;

  typedef struct {
    logic [31:0] s;
    logic        c, o, z, n;
    int          t;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [2:0]        iv, ir, ov, isub, fc, fo, fz, fn, ordy;
  logic [2:0][31:0]  ia, ib, s;
  logic [31:0]       s0, s1;
  logic [15:0]       s2;
  logic              ordy0;
  logic              rnd_ready;
  logic              lat_chk;
  int                cyc = 0;
  int                checks = 0;
  int                errors = 0;
  int                lat [3] = '{3, 0, 1};
  exp_t              q0[$], q1[$], q2[$];

  assign s    = {{16'h0, s2}, s1, s0};
  assign ordy = {1'b1, 1'b1, ordy0};

  pipelined_addsub_nbits #(.WIDTH(32), .STAGES(4)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(ia[0]), .b(ib[0]),
    .op_sub(isub[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .s(s0), .carry_out(fc[0]),
    .overflow(fo[0]), .zero(fz[0]), .negative(fn[0]));

  pipelined_addsub_nbits #(.WIDTH(32), .STAGES(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(ia[1]), .b(ib[1]),
    .op_sub(isub[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .s(s1), .carry_out(fc[1]),
    .overflow(fo[1]), .zero(fz[1]), .negative(fn[1]));

  pipelined_addsub_nbits #(.WIDTH(16), .STAGES(2)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(ia[2][15:0]),
    .b(ib[2][15:0]), .op_sub(isub[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .s(s2),
    .carry_out(fc[2]), .overflow(fo[2]), .zero(fz[2]), .negative(fn[2]));

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    ordy0 = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] rs, input logic c, o, z, n);
    exp_t e;
    e.s = rs; e.c = c; e.o = o; e.z = z; e.n = n; e.t = 0;
    return e;
  endfunction

  // Independent reference: overflow from operand/result signs rather than carries.
  function automatic exp_t model(input logic [31:0] x, y, input logic sub);
    logic [32:0] r;
    logic [31:0] ye;
    logic        ovf;
    ye  = sub ? ~y : y;
    r   = {1'b0, x} + {1'b0, ye} + {32'b0, sub};
    ovf = sub ? (x[31] != y[31] && r[31] != x[31]) : (x[31] == y[31] && r[31] != x[31]);
    return mk(r[31:0], r[32], ovf, r[31:0] == 32'h0, r[31]);
  endfunction

  // Monitor: handshake rule, stall stability, and in-order scoreboard pop.
  logic [36:0] saved [3];
  logic        stall_prev [3] = '{1'b0, 1'b0, 1'b0};
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        stall_prev[d] = 1'b0;
      end else begin
        chk($sformatf("d%0d_in_ready", d), ir[d], !(ov[d] && !ordy[d]));
        if (stall_prev[d])
          chk($sformatf("d%0d_stall_stable", d), {ov[d], s[d], fc[d], fo[d], fz[d], fn[d]}, saved[d]);
        stall_prev[d] = ov[d] && !ordy[d];
        saved[d]      = {ov[d], s[d], fc[d], fo[d], fz[d], fn[d]};
        if (ov[d] && ordy[d]) begin
          exp_t e;
          int   sz;
          case (d)
            0: sz = q0.size();
            1: sz = q1.size();
            default: sz = q2.size();
          endcase
          if (sz == 0) begin
            chk($sformatf("d%0d_spurious_output", d), 1, 0);
          end else begin
            case (d)
              0: e = q0.pop_front();
              1: e = q1.pop_front();
              default: e = q2.pop_front();
            endcase
            chk($sformatf("d%0d_s", d), s[d], e.s);
            chk($sformatf("d%0d_flags_cozn", d), {fc[d], fo[d], fz[d], fn[d]}, {e.c, e.o, e.z, e.n});
            if (lat_chk) chk($sformatf("d%0d_latency", d), cyc - e.t, lat[d]);
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int d, input logic [31:0] x, y, input logic sub, input exp_t e);
    int   n;
    logic r;
    ia[d] = x; ib[d] = y; isub[d] = sub; iv[d] = 1'b1;
    n = 0;
    do begin
      #3;
      r = ir[d];
      @(posedge clk); #1;
      n++;
    end while (!r && n < 200);
    if (!r) chk($sformatf("d%0d_accept_timeout", d), 1, 0);
    e.t = cyc;
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic idle(input int n);
    iv = '0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n = 0;
    iv = '0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_pending", q0.size() + q1.size() + q2.size(), 0);
  endtask

  logic [31:0] va32 [5] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd7, 32'h80000000};
  logic [31:0] vs32 [5] = '{32'h80000000, 32'h0, 32'hFFFFFFFE, 32'd2, 32'h7FFFFFFF};
  logic [31:0] va16 [5] = '{32'h7FFF, 32'hFFFF, 32'd5, 32'd7, 32'h8000};
  logic [31:0] vs16 [5] = '{32'h8000, 32'h0, 32'hFFFE, 32'd2, 32'h7FFF};
  logic [31:0] vb   [5] = '{32'd1, 32'd1, 32'd7, 32'd5, 32'd1};
  logic        vsub [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [3:0]  vcozn[5] = '{4'b0101, 4'b1010, 4'b0001, 4'b1000, 4'b1100};

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rnd_ready = 1'b0; lat_chk = 1'b1;
    iv = '0; ia = '0; ib = '0; isub = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d_reset_out_valid", d), ov[d], 0);
      chk($sformatf("d%0d_reset_s_flags", d), {s[d], fc[d], fo[d], fz[d], fn[d]}, 0);
      chk($sformatf("d%0d_reset_in_ready", d), ir[d], 1);
    end

    // Directed overflow/carry/borrow vectors on every configuration.
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 5; i++) begin
        logic [3:0] f;
        f = vcozn[i];
        send(d, (d == 2) ? va16[i] : va32[i], vb[i], vsub[i],
             mk((d == 2) ? vs16[i] : vs32[i], f[3], f[2], f[1], f[0]));
        if (i == 0) idle(6);
      end
      idle(6);
    end
    drain();

    // Back-to-back random ops with a randomly stalling consumer.
    lat_chk = 1'b0; rnd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [31:0] x, y;
      logic        sb;
      x  = (i % 5 == 0) ? 32'h80000000 : $urandom;
      y  = (i % 7 == 0) ? 32'hFFFFFFFF : $urandom;
      sb = 1'($urandom_range(0, 1));
      send(0, x, y, sb, model(x, y, sb));
    end
    iv = '0;
    repeat (4) begin @(posedge clk); #1; end
    rnd_ready = 1'b0;
    drain();

    // Three ops in flight, then a one-cycle reset: none may emerge.
    lat_chk = 1'b1;
    send(0, 32'd10, 32'd20, 1'b0, mk(32'd30, 0, 0, 0, 0));
    send(0, 32'd11, 32'd21, 1'b0, mk(32'd32, 0, 0, 0, 0));
    send(0, 32'd12, 32'd22, 1'b0, mk(32'd34, 0, 0, 0, 0));
    iv = '0;
    q0.delete();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("flush_out_valid", ov[0], 0);
    chk("flush_s_flags", {s[0], fc[0], fo[0], fz[0], fn[0]}, 0);
    chk("flush_in_ready", ir[0], 1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("flush_no_emerge", ov[0], 0);
    end

    // Pipeline still healthy after the flush.
    send(0, 32'hFFFFFFFF, 32'd1, 1'b0, mk(32'h0, 1, 0, 1, 0));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
